sequential_divider: RTL and testbench
=====================================

# sequential_divider

Multi-cycle restoring unsigned divider: a 2N-bit dividend divided by an N-bit divisor gives an N-bit quotient and an N-bit remainder. It is the arithmetic counterpart of the team's shift-and-add sequential multiplier, and it uses the same start/done handshake so both units can share one datapath controller. It computes one quotient bit per clock. Divide-by-zero and quotient overflow are detected and reported before any iteration runs.

## Interface
- N, default 8: divisor, quotient and remainder width; the dividend is 2N bits.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- dividend  input  2N  unsigned dividend; captured on the accepted start edge.
- divisor  input  N  unsigned divisor; captured on the accepted start edge.
- quotient  output  N  result; registered, written only on entry to DONE.
- remainder  output  N  result; registered, written only on entry to DONE.
- busy  output  1  high in CHECK and ITER.
- done  output  1  high in DONE; held until the next accepted start or reset.
- div_by_zero  output  1  error flag for the current result; valid while done.
- overflow  output  1  error flag for the current result (quotient does not fit in N bits); valid while done.

## Operation
- States:
  - IDLE: waiting for start.
  - CHECK: classify the captured operands.
  - ITER: compute one quotient bit per cycle.
  - DONE: hold results.
- IDLE or DONE with start=1:
  - Capture the dividend into an internal 2N-bit shift register {r, q}, where r is the high half and q the low half.
  - Capture the divisor into d.
  - Clear done, div_by_zero and overflow; set busy; go to CHECK.
  - quotient and remainder keep their old values until the next entry to DONE.
- IDLE with start=0: hold. DONE with start=0: hold all outputs.
- CHECK:
  - If d==0: div_by_zero=1, quotient={N{1}}, remainder=dividend[N-1:0]; go to DONE.
  - Else if r>=d: overflow=1, quotient={N{1}}, remainder=0; go to DONE.
  - Else: load the iteration counter with N; go to ITER.
  - div_by_zero has priority over overflow.
- ITER, each cycle:
  - Form t={r, q[N-1]} (N+1 bits); shift q left by one.
  - If t>=d: r=t-d and q[0]=1. Otherwise r=t[N-1:0] and q[0]=0.
  - Decrement the counter.
  - After the cycle that drives the counter to 0: quotient=q, remainder=r, done=1, busy=0; go to DONE.
- Invariant r<d holds every cycle, so the N+1-bit compare/subtract is sufficient; there are no signed operands.
- start while busy is ignored; operands are not re-sampled.
- Any cycle with reset=1 forces the values below, overriding start and any operation in flight:
  - state=IDLE, quotient=0, remainder=0.
  - busy=0, done=0, div_by_zero=0, overflow=0.
  - Counter and internal registers cleared.

## Timing
- Label the accepted start edge as edge 0.
- Edge 1 (CHECK): error cases set done=1 and busy=0 here. Error latency is 1 cycle after the start edge.
- Normal case: ITER runs on edges 2..N+1. done=1 and results are valid after edge N+1. For N=8 that is 9 edges after the start edge.
- busy is high from just after edge 0 until the DONE transition.
- done is low for exactly the cycles between an accepted start and DONE entry.
- Back-to-back operation:
  - start held high in DONE is accepted on the first DONE edge; done drops after that edge.
  - The minimum normal operation period is therefore N+2 cycles.
- Reset asserted on the same edge as start: reset wins.
- Reset released: the first start can be accepted on the next edge.

## Test plan
- N=8, dividend=0x0064 (100), divisor=0x07, 1-cycle start → busy for 9 cycles. Then done=1, quotient=0x0E, remainder=0x02, both flags 0.
- dividend=0x11FF, divisor=0x12 (largest in-range case) → quotient=0xFF, remainder=0x11, overflow=0, done after edge 9.
- dividend=0x1234, divisor=0x12 → overflow=1 with done after edge 1, quotient=0xFF, remainder=0x00. Then dividend=0x00AB, divisor=0x00 → div_by_zero=1, overflow=0, quotient=0xFF, remainder=0xAB.
- Start 200/3, then pulse start with 50/5 at edge 4 → second request ignored. Result after edge 9: quotient=0x42, remainder=0x02.
- Start 0xFFFE/0xFF, then assert reset at edge 5 → all outputs 0, state IDLE. A subsequent start with 0x0000/0x01 gives quotient=0, remainder=0.
- start held high continuously with 0x0100/0x02 → repeating cycles of done=1 for 1 cycle then low for 9 cycles. quotient=0x80, remainder=0 each pass.

Source files
------------

// File: rtl/sequential_divider.sv
// Multi-cycle restoring unsigned divider: 2N-bit dividend / N-bit divisor.
// One quotient bit per clock; divide-by-zero and quotient overflow are
// resolved in a single classification cycle before any iteration runs.
module sequential_divider #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_ITER  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int         CW      = $clog2(N + 1);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  r_q, r_d;        // partial remainder (high half of shift reg)
  logic [N-1:0]  q_q, q_d;        // dividend low half, becomes the quotient
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  // One restoring step; r<d always holds, so N+1 bits cover the compare.
  logic [N:0]    t;
  logic [N:0]    diff;
  logic          ge;
  logic [N-1:0]  r_step;
  logic [N-1:0]  q_step;

  assign t      = {r_q, q_q[N-1]};
  assign diff   = t - {1'b0, d_q};
  assign ge     = (t >= {1'b0, d_q});
  assign r_step = ge ? diff[N-1:0] : t[N-1:0];
  assign q_step = {q_q[N-2:0], ge};

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          {r_d, q_d} = dividend;
          d_d        = divisor;
          done_d     = 1'b0;
          dbz_d      = 1'b0;
          ovf_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (d_q == '0) begin
          dbz_d   = 1'b1;
          quot_d  = '1;
          rem_d   = q_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (r_q >= d_q) begin
          ovf_d   = 1'b1;
          quot_d  = '1;
          rem_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = CW'(N);
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_d  = q_step;
          rem_d   = r_step;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider (N=8): stimulus pushes expected
// results computed with plain integer division; a monitor pops on each
// rising edge of done and checks values and arrival cycle.
module tb_sequential_divider;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [2*N-1:0] dividend = '0;
  logic [N-1:0]   divisor = '0;
  logic [N-1:0]   quotient, remainder;
  logic           busy, done, div_by_zero, overflow;

  sequential_divider #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend),
    .divisor(divisor), .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
    logic         o;
    int           at_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   ndone = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, longint got, longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // Reference: integer division straight from the operand rules.
  function automatic exp_t model(logic [2*N-1:0] dd, logic [N-1:0] dv, int e);
    exp_t x;
    int a, b;
    a = int'(dd);
    b = int'(dv);
    x.z = 1'b0; x.o = 1'b0;
    if (b == 0) begin
      x.z = 1'b1; x.q = '1; x.r = dd[N-1:0]; x.at_cyc = e + 1;
    end else if (a / b > (1 << N) - 1) begin
      x.o = 1'b1; x.q = '1; x.r = '0; x.at_cyc = e + 1;
    end else begin
      x.q = N'(a / b); x.r = N'(a % b); x.at_cyc = e + N + 1;
    end
    return x;
  endfunction

  // Monitor: one pop per new result.
  initial begin
    logic dprev;
    exp_t e;
    dprev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        dprev = 1'b0;
      end else begin
        if (busy && done) chk("busy_and_done", 1, 0);
        if (done && !dprev) begin
          ndone++;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div_by_zero", div_by_zero, e.z);
            chk("overflow", overflow, e.o);
            chk("busy_at_done", busy, 0);
            chk("done_cycle", cyc, e.at_cyc);
          end
        end
        dprev = done;
      end
    end
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, "_quotient"}, quotient, 0);
    chk({tag, "_remainder"}, remainder, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_dbz"}, div_by_zero, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  // Present one request for one cycle; returns at the negedge after the accept edge.
  task automatic issue(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
    @(negedge clk);
    start = 1'b1; dividend = dd; divisor = dv;
    exp_q.push_back(model(dd, dv, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
  endtask

  task automatic wait_done(input int n0, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (ndone > n0) return;
      @(negedge clk); #1;
    end
    chk("timeout_waiting_done", 1, 0);
  endtask

  task automatic run(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
    int n0;
    n0 = ndone;
    issue(dd, dv);
    wait_done(n0, 3 * N);
  endtask

  initial begin
    int n0;
    logic [N-1:0] dv;
    logic [2*N-1:0] dd;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Directed cases.
    run(16'h0064, 8'h07);
    run(16'h11FF, 8'h12);
    run(16'h1234, 8'h12);
    run(16'h00AB, 8'h00);
    run(16'h0000, 8'h01);

    // Start pulsed while busy must be ignored.
    n0 = ndone;
    issue(16'd200, 8'd3);
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 16'd50; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(n0, 3 * N);
    repeat (3) @(negedge clk);
    chk("ignored_start_no_restart", busy, 0);

    // Reset while an error result is held.
    n0 = ndone;
    issue(16'hFFFE, 8'hFF);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_in_done");
    reset = 1'b0;
    chk("reset_in_done_seen_result", ndone - n0, 1);

    // Reset aborting a normal operation mid-iteration.
    issue(16'h0064, 8'h07);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check_reset_outputs("reset_abort");
    reset = 1'b0;
    run(16'h0000, 8'h01);

    // Reset and start on the same edge: reset wins.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; dividend = 16'h0064; divisor = 8'h07;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("reset_beats_start_busy", busy, 0);
    @(negedge clk);
    chk("reset_beats_start_idle", busy, 0);
    run(16'h0064, 8'h07);

    // start held high: back-to-back passes from DONE.
    @(negedge clk);
    start = 1'b1; dividend = 16'h0100; divisor = 8'h02;
    exp_q.push_back(model(16'h0100, 8'h02, cyc + 1));
    for (int p = 0; p < 3; p++) begin
      n0 = ndone;
      wait_done(n0, 3 * N);
      if (p < 2) exp_q.push_back(model(16'h0100, 8'h02, cyc + 1));
      else start = 1'b0;
    end
    repeat (2) @(negedge clk);

    // Randomized traffic across normal, overflow and zero-divisor cases.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0: dv = 8'h00;
        default: dv = N'($urandom_range(1, (1 << N) - 1));
      endcase
      if ($urandom_range(0, 3) == 0) dd = (2*N)'($urandom);
      else dd = (2*N)'($urandom_range(0, int'(dv) * (1 << N) + 255) % 65536);
      run(dd, dv);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
